// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register, load extraction, result select, regfile write port, forwarding tap, instret
//   in:  clk, rst_n (async, active low), stall, flush, in_* fields from the memory stage
//   out: RegWrite/as3/WD register file write port, wb_valid, fwd_valid/fwd_rd/fwd_data forwarding tap, instret
module writeback_stage #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic                 in_reg_write,
  input  logic [4:0]           in_rd,
  input  logic [1:0]           in_result_src,
  input  logic [2:0]           in_funct3,
  input  logic [WIDTH-1:0]     in_alu_result,
  input  logic [WIDTH-1:0]     in_mem_rdata,
  input  logic [WIDTH-1:0]     in_pc_plus4,
  input  logic [WIDTH-1:0]     in_imm,
  output logic                 RegWrite,
  output logic [4:0]           as3,
  output logic [WIDTH-1:0]     WD,
  output logic                 wb_valid,
  output logic                 fwd_valid,
  output logic [4:0]           fwd_rd,
  output logic [WIDTH-1:0]     fwd_data,
  output logic [CNT_WIDTH-1:0] instret
);
  logic                 valid_q, valid_d, reg_write_q, reg_write_d;
  logic [4:0]           rd_q, rd_d;
  logic [1:0]           result_src_q, result_src_d;
  logic [2:0]           funct3_q, funct3_d;
  logic [WIDTH-1:0]     alu_result_q, alu_result_d, mem_rdata_q, mem_rdata_d;
  logic [WIDTH-1:0]     pc_plus4_q, pc_plus4_d, imm_q, imm_d;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;
  logic                 retire;
  logic [7:0]           byte_v;
  logic [15:0]          half_v;
  logic [WIDTH-1:0]     load_v;
  // flush wins over stall; a flushed stage is fully zeroed
  always_comb begin
    valid_d      = flush ? 1'b0  : stall ? valid_q      : in_valid;
    reg_write_d  = flush ? 1'b0  : stall ? reg_write_q  : in_reg_write;
    rd_d         = flush ? '0    : stall ? rd_q         : in_rd;
    result_src_d = flush ? '0    : stall ? result_src_q : in_result_src;
    funct3_d     = flush ? '0    : stall ? funct3_q     : in_funct3;
    alu_result_d = flush ? '0    : stall ? alu_result_q : in_alu_result;
    mem_rdata_d  = flush ? '0    : stall ? mem_rdata_q  : in_mem_rdata;
    pc_plus4_d   = flush ? '0    : stall ? pc_plus4_q   : in_pc_plus4;
    imm_d        = flush ? '0    : stall ? imm_q        : in_imm;
    // the occupant leaves on any non-stalled edge, or when flushed away
    retire       = valid_q & (~stall | flush);
    instret_d    = instret_q + CNT_WIDTH'(retire);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      result_src_q <= '0;
      funct3_q     <= '0;
      alu_result_q <= '0;
      mem_rdata_q  <= '0;
      pc_plus4_q   <= '0;
      imm_q        <= '0;
      instret_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      rd_q         <= rd_d;
      result_src_q <= result_src_d;
      funct3_q     <= funct3_d;
      alu_result_q <= alu_result_d;
      mem_rdata_q  <= mem_rdata_d;
      pc_plus4_q   <= pc_plus4_d;
      imm_q        <= imm_d;
      instret_q    <= instret_d;
    end
  end
  // half selection ignores off[0]; misaligned halves are trapped upstream
  always_comb begin
    byte_v = mem_rdata_q[{alu_result_q[1:0], 3'b000} +: 8];
    half_v = alu_result_q[1] ? mem_rdata_q[31:16] : mem_rdata_q[15:0];
    load_v = funct3_q == 3'b000 ? {{(WIDTH-8){byte_v[7]}}, byte_v} :
             funct3_q == 3'b100 ? {{(WIDTH-8){1'b0}}, byte_v} :
             funct3_q == 3'b001 ? {{(WIDTH-16){half_v[15]}}, half_v} :
             funct3_q == 3'b101 ? {{(WIDTH-16){1'b0}}, half_v} : mem_rdata_q;
    WD     = result_src_q == 2'b00 ? alu_result_q :
             result_src_q == 2'b01 ? load_v :
             result_src_q == 2'b10 ? pc_plus4_q : imm_q;
  end
  assign RegWrite  = valid_q & reg_write_q & (rd_q != 5'd0);
  assign as3       = rd_q;
  assign wb_valid  = valid_q;
  assign fwd_valid = RegWrite;
  assign fwd_rd    = rd_q;
  assign fwd_data  = WD;
  assign instret   = instret_q;
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline register plus writeback logic for the RV32I core.
- Captures the completing instruction from the memory stage and aligns and sign- or zero-extends load data.
- Selects the result, then drives the register file write port (RegWrite, as3, WD) and an execute-stage forwarding tap.
- Keeps a retired-instruction counter.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported because load alignment is RV32-specific.
- CNT_WIDTH, 64, width of the retired-instruction counter.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  hold the stage register contents
- flush  input  1  load a bubble instead of the incoming instruction
- in_valid  input  1  memory stage holds a real instruction
- in_reg_write  input  1  instruction writes rd
- in_rd  input  5  destination register
- in_result_src  input  2  00 ALU, 01 load, 10 PC+4, 11 immediate (LUI)
- in_funct3  input  3  load size/sign encoding
- in_alu_result  input  WIDTH  ALU result; bits [1:0] are the load byte offset
- in_mem_rdata  input  WIDTH  raw aligned-word data from data memory
- in_pc_plus4  input  WIDTH  link value
- in_imm  input  WIDTH  U-type immediate
- RegWrite  output  1  register file write enable
- as3  output  5  register file write address
- WD  output  WIDTH  register file write data
- wb_valid  output  1  stage holds a real instruction
- fwd_valid  output  1  forwarding tap valid
- fwd_rd  output  5  forwarding destination
- fwd_data  output  WIDTH  forwarding data, equal to WD
- instret  output  CNT_WIDTH  retired-instruction count

Behaviour:
Stage register update:
- Registered fields: valid, reg_write, rd, result_src, funct3, alu_result, mem_rdata, pc_plus4, imm.
- Reset (rst_n low, asynchronous): every field is 0 and instret is 0. All outputs are therefore 0.
- Each rising edge, in priority order:
  - flush=1: valid<=0; other fields don't care, but are zeroed.
  - else stall=1: all fields hold.
  - else: all fields load from the in_* ports.
- Latency: an instruction presented in cycle N drives RegWrite/as3/WD during cycle N+1. The register file commits it at the end of cycle N+1.

Load extraction (combinational, from registered fields):
- off = alu_result[1:0].
- Byte = mem_rdata[8*off+7 : 8*off].
- Half = mem_rdata[31:16] if off[1], else mem_rdata[15:0]. off[0] is ignored; misalignment is trapped upstream.
- funct3 000 LB: sign-extend byte.
- funct3 100 LBU: zero-extend byte.
- funct3 001 LH: sign-extend half.
- funct3 101 LHU: zero-extend half.
- funct3 010 and all other codes: full word.

Result mux:
- WD = ALU / load value / pc_plus4 / imm, selected by result_src.
- WD is combinational from the stage register only and never depends on in_* ports in the same cycle.

Register file write port:
- RegWrite = valid & reg_write & (rd != 0). Writes to x0 are suppressed.
- as3 = rd.
- While stalled, the same write repeats each cycle. This is idempotent and allowed.

Forwarding:
- fwd_valid = RegWrite, fwd_rd = rd, fwd_data = WD.
- Needed because register file reads are combinational and return the pre-write value in the write cycle.

instret:
- Increments by 1 on an edge where valid & (~stall | flush), i.e. the current occupant leaves the stage.
- Bubbles never count.
- Wraps modulo 2^CNT_WIDTH.

Reset mid-operation:
- Asynchronous assertion zeroes the stage and the counter immediately.
- RegWrite drops in the same cycle, without waiting for an edge.

Test Plan:
- Reset with stage valid, RegWrite=1, instret=5 → all outputs 0 immediately on rst_n fall, before the next edge; after release, outputs stay 0 until a valid instruction enters.
- in_valid=1, reg_write=1, rd=7, src=00, alu=0x1234_5678 → next cycle RegWrite=1, as3=7, WD=0x12345678, fwd_valid=1; after the following edge instret=1.
- Loads with mem_rdata=0x80F0_7F81:
  - LB off=0 → WD=0xFFFFFF81
  - LBU off=3 → WD=0x00000080
  - LH off=2 → WD=0xFFFF80F0
  - LHU off=0 → WD=0x00007F81
  - LW → WD=0x80F07F81
- rd=0, reg_write=1, src=11, imm=0xABCDE000 → RegWrite=0, fwd_valid=0, wb_valid=1; instret still increments.
- Valid instruction held with stall=1 for 3 cycles → RegWrite/WD constant for 3 cycles; instret increments once, on the release edge.
- stall=1 and flush=1 together with a valid occupant → next cycle wb_valid=0 and RegWrite=0; instret +1; the incoming instruction is dropped.
